// File: rtl/ccip_localmem_responder.sv
// CCI-P read/write responder backed by one local-memory Avalon-MM bank.
// Per-channel request FIFOs feed a two-state issue FSM; read tags are queued until data returns.
module ccip_localmem_responder #(
  parameter int unsigned ADDR_W             = 26,
  parameter int unsigned REQ_DEPTH          = 16,
  parameter int unsigned ALMFULL_MARGIN     = 4,
  parameter int unsigned MAX_RD_OUTSTANDING = 32
) (
  input  logic              clk,
  input  logic              SoftReset_n,
  input  logic              c0_req_valid,
  input  logic [41:0]       c0_req_addr,
  input  logic [15:0]       c0_req_mdata,
  input  logic              c1_req_valid,
  input  logic [41:0]       c1_req_addr,
  input  logic [511:0]      c1_req_data,
  input  logic [15:0]       c1_req_mdata,
  output logic              c0_almfull,
  output logic              c1_almfull,
  output logic              c0_rsp_valid,
  output logic [511:0]      c0_rsp_data,
  output logic [15:0]       c0_rsp_mdata,
  output logic              c1_rsp_valid,
  output logic [15:0]       c1_rsp_mdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [511:0]      avm_writedata,
  output logic [63:0]       avm_byteenable,
  output logic [6:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [511:0]      avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int unsigned PtrW    = $clog2(REQ_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned TagPtrW = $clog2(MAX_RD_OUTSTANDING);
  localparam int unsigned OutW    = TagPtrW + 1;
  localparam logic [CntW-1:0] AlmThresh = CntW'(REQ_DEPTH - ALMFULL_MARGIN);
  localparam logic [CntW-1:0] FifoFull  = CntW'(REQ_DEPTH);
  localparam logic [OutW-1:0] OutMax    = OutW'(MAX_RD_OUTSTANDING);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Line address bits above ADDR_W are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c0_req_addr[41:ADDR_W], c1_req_addr[41:ADDR_W]};

  // Request FIFO storage
  logic [ADDR_W-1:0] c0_addr_mem [REQ_DEPTH];
  logic [15:0]       c0_tag_mem  [REQ_DEPTH];
  logic [ADDR_W-1:0] c1_addr_mem [REQ_DEPTH];
  logic [511:0]      c1_data_mem [REQ_DEPTH];
  logic [15:0]       c1_tag_mem  [REQ_DEPTH];
  logic [15:0]       rd_tag_mem  [MAX_RD_OUTSTANDING];

  logic [PtrW-1:0]    c0_wptr_q, c0_rptr_q, c1_wptr_q, c1_rptr_q;
  logic [CntW-1:0]    c0_cnt_q, c0_cnt_d, c1_cnt_q, c1_cnt_d;
  logic               c0_almfull_q, c1_almfull_q;
  logic [TagPtrW-1:0] tag_wptr_q, tag_rptr_q;
  logic [OutW-1:0]    rd_cnt_q, rd_cnt_d, rd_eff;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;  // 0: c0 wins a tie, 1: c1 wins a tie
  logic               avm_read_q, avm_read_d, avm_write_q, avm_write_d;
  logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic [511:0]       avm_writedata_q, avm_writedata_d;
  logic [15:0]        cur_tag_q, cur_tag_d;

  logic               c0_rsp_valid_q, c1_rsp_valid_q;
  logic [511:0]       c0_rsp_data_q;
  logic [15:0]        c0_rsp_mdata_q, c1_rsp_mdata_q;

  logic c0_push, c1_push, c0_pop, c1_pop;
  logic accept, acc_rd, acc_wr, can_load, rd_cand, wr_cand, sel_rd, load, strobe_ok;

  assign c0_push   = c0_req_valid && (c0_cnt_q != FifoFull);
  assign c1_push   = c1_req_valid && (c1_cnt_q != FifoFull);
  assign accept    = (state_q == StIssue) && !avm_waitrequest;
  assign acc_rd    = accept && avm_read_q;
  assign acc_wr    = accept && avm_write_q;
  assign can_load  = (state_q == StIdle) || accept;
  // A read held in ISSUE already owns an outstanding slot, accepted yet or not.
  assign rd_eff    = rd_cnt_q + OutW'((state_q == StIssue) && avm_read_q);
  assign rd_cand   = (c0_cnt_q != '0) && (rd_eff < OutMax);
  assign wr_cand   = (c1_cnt_q != '0);
  assign sel_rd    = rd_cand && (!wr_cand || !prio_q);
  assign load      = can_load && (rd_cand || wr_cand);
  // Strobes with nothing outstanding are stale returns from before a reset.
  assign strobe_ok = avm_readdatavalid && (rd_cnt_q != '0);

  assign c0_cnt_d = c0_cnt_q + CntW'(c0_push) - CntW'(c0_pop);
  assign c1_cnt_d = c1_cnt_q + CntW'(c1_push) - CntW'(c1_pop);
  assign rd_cnt_d = rd_cnt_q + OutW'(acc_rd) - OutW'(strobe_ok);

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    cur_tag_d       = cur_tag_q;
    c0_pop          = 1'b0;
    c1_pop          = 1'b0;
    if (accept) begin
      state_d     = StIdle;
      avm_read_d  = 1'b0;
      avm_write_d = 1'b0;
    end
    if (load) begin
      state_d = StIssue;
      if (rd_cand && wr_cand) prio_d = ~prio_q;
      if (sel_rd) begin
        c0_pop        = 1'b1;
        avm_read_d    = 1'b1;
        avm_address_d = c0_addr_mem[c0_rptr_q];
        cur_tag_d     = c0_tag_mem[c0_rptr_q];
      end else begin
        c1_pop          = 1'b1;
        avm_write_d     = 1'b1;
        avm_address_d   = c1_addr_mem[c1_rptr_q];
        avm_writedata_d = c1_data_mem[c1_rptr_q];
        cur_tag_d       = c1_tag_mem[c1_rptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (c0_push) begin
      c0_addr_mem[c0_wptr_q] <= c0_req_addr[ADDR_W-1:0];
      c0_tag_mem[c0_wptr_q]  <= c0_req_mdata;
    end
    if (c1_push) begin
      c1_addr_mem[c1_wptr_q] <= c1_req_addr[ADDR_W-1:0];
      c1_data_mem[c1_wptr_q] <= c1_req_data;
      c1_tag_mem[c1_wptr_q]  <= c1_req_mdata;
    end
    if (acc_rd) rd_tag_mem[tag_wptr_q] <= cur_tag_q;
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      c0_wptr_q       <= '0;
      c0_rptr_q       <= '0;
      c1_wptr_q       <= '0;
      c1_rptr_q       <= '0;
      c0_cnt_q        <= '0;
      c1_cnt_q        <= '0;
      c0_almfull_q    <= 1'b0;
      c1_almfull_q    <= 1'b0;
      tag_wptr_q      <= '0;
      tag_rptr_q      <= '0;
      rd_cnt_q        <= '0;
      state_q         <= StIdle;
      prio_q          <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      cur_tag_q       <= '0;
      c0_rsp_valid_q  <= 1'b0;
      c0_rsp_data_q   <= '0;
      c0_rsp_mdata_q  <= '0;
      c1_rsp_valid_q  <= 1'b0;
      c1_rsp_mdata_q  <= '0;
    end else begin
      if (c0_push) c0_wptr_q <= c0_wptr_q + PtrW'(1);
      if (c0_pop)  c0_rptr_q <= c0_rptr_q + PtrW'(1);
      if (c1_push) c1_wptr_q <= c1_wptr_q + PtrW'(1);
      if (c1_pop)  c1_rptr_q <= c1_rptr_q + PtrW'(1);
      c0_cnt_q     <= c0_cnt_d;
      c1_cnt_q     <= c1_cnt_d;
      c0_almfull_q <= (c0_cnt_d >= AlmThresh);
      c1_almfull_q <= (c1_cnt_d >= AlmThresh);
      if (acc_rd)    tag_wptr_q <= tag_wptr_q + TagPtrW'(1);
      if (strobe_ok) tag_rptr_q <= tag_rptr_q + TagPtrW'(1);
      rd_cnt_q        <= rd_cnt_d;
      state_q         <= state_d;
      prio_q          <= prio_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      cur_tag_q       <= cur_tag_d;
      c0_rsp_valid_q  <= strobe_ok;
      if (strobe_ok) begin
        c0_rsp_data_q  <= avm_readdata;
        c0_rsp_mdata_q <= rd_tag_mem[tag_rptr_q];
      end
      c1_rsp_valid_q <= acc_wr;
      if (acc_wr) c1_rsp_mdata_q <= cur_tag_q;
    end
  end

  assign c0_almfull     = c0_almfull_q;
  assign c1_almfull     = c1_almfull_q;
  assign c0_rsp_valid   = c0_rsp_valid_q;
  assign c0_rsp_data    = c0_rsp_data_q;
  assign c0_rsp_mdata   = c0_rsp_mdata_q;
  assign c1_rsp_valid   = c1_rsp_valid_q;
  assign c1_rsp_mdata   = c1_rsp_mdata_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = '1;
  assign avm_burstcount = 7'd1;

endmodule

// File: tb/tb_ccip_localmem_responder.sv
// Bench for ccip_localmem_responder: Avalon slave model with fixed read latency,
// response scoreboards for both channels, and directed scenarios.
module tb_ccip_localmem_responder;

  localparam byte CmdR = 8'h52;
  localparam byte CmdW = 8'h57;

  logic         clk = 1'b0;
  logic         SoftReset_n;
  logic         c0_req_valid, c1_req_valid;
  logic [41:0]  c0_req_addr, c1_req_addr;
  logic [15:0]  c0_req_mdata, c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_almfull, c1_almfull;
  logic         c0_rsp_valid, c1_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic [25:0]  avm_address;
  logic         avm_read, avm_write;
  logic [511:0] avm_writedata;
  logic [63:0]  avm_byteenable;
  logic [6:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [511:0] avm_readdata;
  logic         avm_readdatavalid;

  ccip_localmem_responder dut (
    .clk               (clk),
    .SoftReset_n       (SoftReset_n),
    .c0_req_valid      (c0_req_valid),
    .c0_req_addr       (c0_req_addr),
    .c0_req_mdata      (c0_req_mdata),
    .c1_req_valid      (c1_req_valid),
    .c1_req_addr       (c1_req_addr),
    .c1_req_data       (c1_req_data),
    .c1_req_mdata      (c1_req_mdata),
    .c0_almfull        (c0_almfull),
    .c1_almfull        (c1_almfull),
    .c0_rsp_valid      (c0_rsp_valid),
    .c0_rsp_data       (c0_rsp_data),
    .c0_rsp_mdata      (c0_rsp_mdata),
    .c1_rsp_valid      (c1_rsp_valid),
    .c1_rsp_mdata      (c1_rsp_mdata),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [25:0] addr; } pend_t;
  typedef struct { logic [15:0] tag; logic [511:0] data; } rd_exp_t;

  int checks = 0;
  int failures = 0;

  pend_t        pend[$];
  byte          cmd_log[$];
  rd_exp_t      exp_c0[$];
  logic [15:0]  exp_c1[$];
  logic [511:0] slv_mem [logic [25:0]];
  logic [511:0] ref_mem [logic [25:0]];
  int           lat = 2;
  int           inject = 0;
  int           cyc = 0;
  int           issued_pre_ret = 0;
  bit           seen_ret = 1'b0;

  function automatic logic [511:0] default_line(input logic [25:0] a);
    return {16{{6'h0, a} ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [511:0] ref_line(input logic [25:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_line(a);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Avalon slave: samples commands away from the clock edge, returns reads in order.
  always @(negedge clk) begin
    cyc++;
    if (!SoftReset_n) begin
      pend.delete();
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
    end else begin
      if (avm_write && !avm_waitrequest) begin
        slv_mem[avm_address] = avm_writedata;
        cmd_log.push_back(CmdW);
      end
      if (avm_read && !avm_waitrequest) begin
        pend.push_back('{cyc + lat, avm_address});
        cmd_log.push_back(CmdR);
        if (!seen_ret) issued_pre_ret++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = slv_mem.exists(pend[0].addr) ? slv_mem[pend[0].addr]
                                                    : default_line(pend[0].addr);
        void'(pend.pop_front());
        seen_ret = 1'b1;
      end else if (inject > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = '1;
        inject--;
      end else begin
        avm_readdatavalid = 1'b0;
      end
    end
  end

  // Response scoreboards
  always @(negedge clk) begin
    if (SoftReset_n && c0_rsp_valid) begin
      chk("c0_rsp_expected", exp_c0.size() != 0, 1'b1);
      if (exp_c0.size() != 0) begin
        rd_exp_t e;
        e = exp_c0.pop_front();
        chk("c0_rsp_mdata", c0_rsp_mdata, e.tag);
        chk("c0_rsp_data", c0_rsp_data, e.data);
      end
    end
    if (SoftReset_n && c1_rsp_valid) begin
      chk("c1_rsp_expected", exp_c1.size() != 0, 1'b1);
      if (exp_c1.size() != 0) chk("c1_rsp_mdata", c1_rsp_mdata, exp_c1.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    SoftReset_n     = 1'b0;
    c0_req_valid    = 1'b0;
    c1_req_valid    = 1'b0;
    avm_waitrequest = 1'b0;
    inject          = 0;
    repeat (2) step();
    exp_c0.delete();
    exp_c1.delete();
    cmd_log.delete();
    ref_mem.delete();
    slv_mem.delete();
    issued_pre_ret = 0;
    seen_ret       = 1'b0;
    SoftReset_n    = 1'b1;
    step();
  endtask

  task automatic push_rd(input logic [25:0] a, input logic [15:0] tag, input bit expect_it);
    c0_req_valid = 1'b1;
    c0_req_addr  = {16'h0, a};
    c0_req_mdata = tag;
    if (expect_it) exp_c0.push_back('{tag, ref_line(a)});
    step();
    c0_req_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [25:0] a, input logic [511:0] d, input logic [15:0] tag);
    c1_req_valid = 1'b1;
    c1_req_addr  = {16'h0, a};
    c1_req_data  = d;
    c1_req_mdata = tag;
    ref_mem[a]   = d;
    exp_c1.push_back(tag);
    step();
    c1_req_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_c0.size() != 0 || exp_c1.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 512'(exp_c0.size() + exp_c1.size()), '0);
    repeat (4) step();
  endtask

  initial begin
    logic [511:0] pat_a;
    int n;
    SoftReset_n     = 1'b0;
    c0_req_valid    = 1'b0;
    c1_req_valid    = 1'b0;
    c0_req_addr     = '0;
    c1_req_addr     = '0;
    c0_req_mdata    = '0;
    c1_req_mdata    = '0;
    c1_req_data     = '0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata    = '0;
    repeat (3) step();
    chk("rst_c0_almfull", c0_almfull, 1'b0);
    chk("rst_c1_almfull", c1_almfull, 1'b0);
    chk("rst_c0_rsp_valid", c0_rsp_valid, 1'b0);
    chk("rst_c1_rsp_valid", c1_rsp_valid, 1'b0);
    chk("rst_avm_read", avm_read, 1'b0);
    chk("rst_avm_write", avm_write, 1'b0);
    chk("rst_avm_address", avm_address, '0);
    chk("rst_c0_rsp_data", c0_rsp_data, '0);
    chk("byteenable", avm_byteenable, {64{1'b1}});
    chk("burstcount", avm_burstcount, 7'd1);

    // Write then read back the same line
    do_reset();
    lat   = 3;
    pat_a = {16{32'hA5A5_0001}};
    push_wr(26'h10, pat_a, 16'h0001);
    drain("wr_then_rd_w", 50);
    push_rd(26'h10, 16'h0002, 1'b1);
    drain("wr_then_rd_r", 50);

    // Simultaneous requests alternate R,W,... starting with the read
    do_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) begin
      c0_req_valid = 1'b1;
      c0_req_addr  = 42'h200 + 42'(i);
      c0_req_mdata = 16'h0010 + 16'(i);
      exp_c0.push_back('{16'h0010 + 16'(i), ref_line(26'h200 + 26'(i))});
      c1_req_valid = 1'b1;
      c1_req_addr  = 42'h300 + 42'(i);
      c1_req_data  = {16{32'hC0DE_0000 + 32'(i)}};
      c1_req_mdata = 16'h0020 + 16'(i);
      ref_mem[26'h300 + 26'(i)] = {16{32'hC0DE_0000 + 32'(i)}};
      exp_c1.push_back(16'h0020 + 16'(i));
      step();
    end
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
    drain("arb", 100);
    chk("arb_cmd_count", cmd_log.size(), 8);
    for (int i = 0; i < 8 && i < cmd_log.size(); i++)
      chk($sformatf("arb_order_%0d", i), cmd_log[i], (i % 2 == 0) ? CmdR : CmdW);
    push_rd(26'h303, 16'h0030, 1'b1);
    drain("arb_readback", 50);

    // Waitrequest stall holds the write command stable
    do_reset();
    avm_waitrequest = 1'b1;
    push_wr(26'h55, {16{32'hBEEF_0055}}, 16'h0007);
    n = 0;
    while (!avm_write && n < 20) begin
      step();
      n++;
    end
    chk("stall_write_issued", avm_write, 1'b1);
    repeat (5) begin
      chk("stall_avm_write", avm_write, 1'b1);
      chk("stall_avm_address", avm_address, 26'h55);
      chk("stall_avm_writedata", avm_writedata, {16{32'hBEEF_0055}});
      chk("stall_no_c1_rsp", c1_rsp_valid, 1'b0);
      step();
    end
    avm_waitrequest = 1'b0;
    drain("stall", 50);

    // Outstanding limit: 32 reads in flight before the first return
    do_reset();
    lat = 100;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (c0_almfull && n < 500) begin
        step();
        n++;
      end
      push_rd(26'h400 + 26'(i), 16'(i), 1'b1);
    end
    drain("outstanding", 3000);
    chk("outstanding_pre_return", issued_pre_ret, 32);

    // Almost-full and drop on full, with the issue path blocked by a stalled write
    do_reset();
    lat = 2;
    avm_waitrequest = 1'b1;
    push_wr(26'h60, {16{32'h0000_0060}}, 16'h0099);
    n = 0;
    while (!avm_write && n < 20) begin
      step();
      n++;
    end
    chk("almfull_write_stalled", avm_write, 1'b1);
    for (int i = 0; i < 17; i++) begin
      c0_req_valid = 1'b1;
      c0_req_addr  = 42'h500 + 42'(i);
      c0_req_mdata = 16'h0040 + 16'(i);
      if (i < 16) exp_c0.push_back('{16'h0040 + 16'(i), ref_line(26'h500 + 26'(i))});
      step();
      if (i == 10) chk("almfull_after_11", c0_almfull, 1'b0);
      if (i == 11) chk("almfull_after_12", c0_almfull, 1'b1);
    end
    c0_req_valid = 1'b0;
    chk("almfull_held", c0_almfull, 1'b1);
    chk("c1_almfull_low", c1_almfull, 1'b0);
    avm_waitrequest = 1'b0;
    drain("almfull", 500);
    chk("almfull_cleared", c0_almfull, 1'b0);

    // Reset with reads in flight, then stale strobes
    do_reset();
    lat = 100;
    for (int i = 0; i < 3; i++) push_rd(26'h700 + 26'(i), 16'h0060 + 16'(i), 1'b0);
    n = 0;
    while (cmd_log.size() < 3 && n < 20) begin
      step();
      n++;
    end
    chk("midflight_issued", cmd_log.size(), 3);
    SoftReset_n = 1'b0;
    repeat (2) step();
    chk("midflight_rst_rsp", c0_rsp_valid, 1'b0);
    chk("midflight_rst_read", avm_read, 1'b0);
    SoftReset_n = 1'b1;
    step();
    inject = 3;
    repeat (6) begin
      chk("stale_no_rsp", c0_rsp_valid, 1'b0);
      step();
    end
    lat = 2;
    push_rd(26'h710, 16'h0077, 1'b1);
    drain("post_reset_read", 50);

    chk("final_c0_empty", exp_c0.size(), 0);
    chk("final_c1_empty", exp_c1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccip_localmem_responder.md
Name: ccip_localmem_responder

Overview:
- CCI-P responder that serves AFU read requests (c0) and write requests (c1) out of one local-memory Avalon-MM bank.
- It is the opposite end of the af2cp_sTx/cp2af_sRx traffic that servers_system produces.
- Sits beside soma_app_top and drives one local_mem bank. Lets the BFS services run against on-card DDR instead of host memory.
- Requests are buffered per channel, arbitrated onto Avalon, and answered with the request mdata echoed back.

Parameters:
- ADDR_W, 26, Avalon line-address width; the CCI-P line address is truncated to its low ADDR_W bits.
- REQ_DEPTH, 16, entries in each request FIFO (c0, c1); power of 2.
- ALMFULL_MARGIN, 4, almost-full asserts when FIFO occupancy >= REQ_DEPTH-ALMFULL_MARGIN.
- MAX_RD_OUTSTANDING, 32, reads issued to Avalon but not yet returned; power of 2.

Ports:
- clk  in  1  clock
- SoftReset_n  in  1  asynchronous active-low reset
- c0_req_valid  in  1  read request
- c0_req_addr  in  42  cache-line address
- c0_req_mdata  in  16  request tag
- c1_req_valid  in  1  write request
- c1_req_addr  in  42  cache-line address
- c1_req_data  in  512  write line
- c1_req_mdata  in  16  request tag
- c0_almfull  out  1  c0 FIFO almost full
- c1_almfull  out  1  c1 FIFO almost full
- c0_rsp_valid  out  1  read response
- c0_rsp_data  out  512  read data
- c0_rsp_mdata  out  16  echoed tag
- c1_rsp_valid  out  1  write response
- c1_rsp_mdata  out  16  echoed tag
- avm_address  out  ADDR_W  Avalon address
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  512  Avalon write data
- avm_byteenable  out  64  always all-ones
- avm_burstcount  out  7  always 1
- avm_waitrequest  in  1  Avalon stall
- avm_readdata  in  512  Avalon read data
- avm_readdatavalid  in  1  read data strobe

Behaviour:
Reset (SoftReset_n low, asynchronous):
- All FIFOs empty; outstanding counter 0; arbiter priority set to c0.
- Deasserted: c0_rsp_valid, c1_rsp_valid, avm_read, avm_write, c0_almfull, c1_almfull.
- Data and address outputs reset to 0.

Request FIFOs:
- A valid request is written on the cycle it is presented.
- CCI-P has no ready: the requester must honour almfull.
- A push into a full FIFO is dropped, and the FIFO contents are unaffected.
- almfull is registered from occupancy. It is valid the cycle after the push or pop that crosses the threshold.

Avalon issue FSM, states IDLE, ISSUE:
- IDLE: if a candidate exists, load avm_* from the selected FIFO head, pop it, and go to ISSUE.
- Read candidate: c0 non-empty and outstanding < MAX_RD_OUTSTANDING.
- Write candidate: c1 non-empty.
- Both candidates present: the higher-priority channel is taken and priority toggles. A single candidate is taken without changing priority.
- ISSUE: hold avm_read/avm_write, address and data stable while avm_waitrequest=1.
- ISSUE on acceptance (waitrequest=0):
  - Read: push c0_req_mdata into the read-tag FIFO and increment outstanding.
  - Write: schedule the write response.
  - Then go to IDLE, or back-to-back load the next candidate and stay in ISSUE. At most one command is accepted per cycle.
- avm_address = req_addr[ADDR_W-1:0].

Read return:
- avm_readdatavalid returns in issue order.
- The cycle after a strobe: c0_rsp_valid=1 for one cycle, c0_rsp_data=registered readdata, c0_rsp_mdata=popped tag.
- Latency from acceptance is the Avalon latency +1.
- Outstanding decrements on each strobe. Accept and return in the same cycle leave the count unchanged.
- A strobe when outstanding==0 (stale after reset) is ignored: no response, no underflow.

Write response:
- c1_rsp_valid pulses one cycle after write acceptance, with c1_rsp_mdata = the write's tag.

General:
- c0 and c1 responses are independent and may be asserted in the same cycle.
- No read/write ordering is guaranteed between channels beyond arbitration order.
- Reset mid-operation discards all pending requests, tags and responses. No response pulses follow reset.

Test Plan:
- Write then read: c1 write addr 0x10, data pattern A, mdata 0x0001; then c0 read addr 0x10, mdata 0x0002 -> c1_rsp mdata 0x0001, then c0_rsp data A, mdata 0x0002.
- Simultaneous arbitration: push 4 reads and 4 writes on the same cycles -> Avalon commands alternate R,W,R,W,... starting with R; all 8 tags echoed.
- Waitrequest stall: hold avm_waitrequest=1 for 5 cycles during a write -> address, data and avm_write stable throughout; one c1_rsp after release.
- Outstanding limit: Avalon delays readdata by 100 cycles; push 40 reads -> exactly 32 issued before the first return; c0 responses return in tag order 0..39.
- Almost-full: push 12 reads with Avalon stalled -> c0_almfull=1 the cycle after the 12th push. The 17th push is dropped and the dropped tag never appears.
- Reset mid-flight: assert SoftReset_n low with 3 reads outstanding, release, drive 3 readdatavalid strobes -> no c0_rsp_valid, outstanding stays 0.
